// File: rtl/apb_requester_if.sv
// apb_requester_if: command/response stream plus APB bus bundle for apb_requester
interface apb_requester_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic              cmd_write;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;
    logic [ADDR_W-1:0] paddr;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        input  cmd_valid, cmd_addr, cmd_write, cmd_wdata, rsp_ready, prdata, pready, pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, paddr, psel, penable, pwrite, pwdata
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_write, cmd_wdata, rsp_ready, prdata, pready, pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, paddr, psel, penable, pwrite, pwdata
    );
endinterface

// File: rtl/apb_requester.sv
// apb_requester: single-outstanding command stream to APB SETUP/ACCESS transfers with response stream
module apb_requester #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input logic            clk,
    input logic            rst_n,
    apb_requester_if.master bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;
    localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;

    logic [1:0]        state;
    logic [CW-1:0]     cnt;
    logic [ADDR_W-1:0] addr_in;
    logic [DATA_W-1:0] rd_next;
    logic              misaligned;
    logic              expired;

    assign bus.cmd_ready = (state == IDLE) && rst_n;
    assign addr_in       = bus.cmd_addr;
    assign misaligned    = |addr_in[1:0];
    assign expired       = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT));
    assign rd_next       = (!bus.pwrite && !bus.pslverr) ? bus.prdata : '0;

    // Transfer sequencing; misaligned commands skip the bus, APB fields hold between transfers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            cnt             <= '0;
            bus.psel        <= 1'b0;
            bus.penable     <= 1'b0;
            bus.pwrite      <= 1'b0;
            bus.paddr       <= '0;
            bus.pwdata      <= '0;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_err     <= 1'b0;
            bus.rsp_timeout <= 1'b0;
            bus.rsp_rdata   <= '0;
        end else begin
            case (state)
                IDLE: if (bus.cmd_valid) begin
                    if (misaligned) begin
                        state           <= RESP;
                        bus.rsp_valid   <= 1'b1;
                        bus.rsp_err     <= 1'b1;
                        bus.rsp_timeout <= 1'b0;
                        bus.rsp_rdata   <= '0;
                    end else begin
                        state      <= SETUP;
                        bus.psel   <= 1'b1;
                        bus.paddr  <= addr_in;
                        bus.pwrite <= bus.cmd_write;
                        bus.pwdata <= bus.cmd_wdata;
                    end
                end
                SETUP: begin
                    state       <= ACCESS;
                    bus.penable <= 1'b1;
                    cnt         <= '0;
                end
                ACCESS: begin
                    if (bus.pready || expired) begin
                        state           <= RESP;
                        bus.psel        <= 1'b0;
                        bus.penable     <= 1'b0;
                        bus.rsp_valid   <= 1'b1;
                        bus.rsp_err     <= bus.pready ? bus.pslverr : 1'b1;
                        bus.rsp_timeout <= !bus.pready;
                        bus.rsp_rdata   <= bus.pready ? rd_next : '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: if (bus.rsp_ready) begin
                    state         <= IDLE;
                    bus.rsp_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_apb_requester.sv
// tb_apb_requester: timeline-model checked directed test of apb_requester
module tb_apb_requester;
    localparam int TO = 4;

    logic clk;
    logic rst_n;
    apb_requester_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    apb_requester #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int plan_waits = 0;
    logic plan_err = 1'b0;
    logic [31:0] plan_rdata = '0;
    int n_psel, n_acc, lat;

    bit busy = 0, mis = 0;
    int t = 0, acc_n = 0, rsp_start = 0;
    logic r_err, r_to;
    logic [31:0] r_data;
    logic o_err = 0, o_to = 0;
    logic [31:0] o_data = '0, e_paddr = '0, e_pwdata = '0;
    logic e_pwrite = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction timeline: t counts edges since accept; SETUP at t=1, ACCESS t=2..acc_n+1
    task automatic model_update();
        bit to;
        if (!rst_n) begin
            busy = 0; o_err = 0; o_to = 0; o_data = '0;
            e_paddr = '0; e_pwrite = 0; e_pwdata = '0;
        end else if (busy) begin
            if (t >= rsp_start && bus.rsp_ready) busy = 0;
            else t++;
        end else if (bus.cmd_valid) begin
            busy = 1; t = 1;
            mis = bus.cmd_addr[1:0] != 2'b00;
            to = !mis && TO != 0 && plan_waits > TO;
            acc_n = to ? TO + 1 : plan_waits + 1;
            rsp_start = mis ? 1 : acc_n + 2;
            r_err = mis || to || plan_err;
            r_to = to;
            r_data = (!mis && !to && !bus.cmd_write && !plan_err) ? plan_rdata : 32'h0;
            if (!mis) begin
                e_paddr = bus.cmd_addr; e_pwrite = bus.cmd_write; e_pwdata = bus.cmd_wdata;
            end
        end
        if (busy && t == rsp_start) begin
            o_err = r_err; o_to = r_to; o_data = r_data;
        end
    endtask

    task automatic compare();
        bit in_apb;
        in_apb = busy && !mis && t <= acc_n + 1;
        chk("cmd_ready", bus.cmd_ready, rst_n && !busy);
        chk("psel", bus.psel, in_apb && t >= 1);
        chk("penable", bus.penable, in_apb && t >= 2);
        chk("rsp_valid", bus.rsp_valid, busy && t >= rsp_start);
        chk("rsp_err", bus.rsp_err, o_err);
        chk("rsp_timeout", bus.rsp_timeout, o_to);
        chk("rsp_rdata", bus.rsp_rdata, o_data);
        chk("paddr", bus.paddr, e_paddr);
        chk("pwrite", bus.pwrite, e_pwrite);
        chk("pwdata", bus.pwdata, e_pwdata);
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        compare();
        if (bus.psel) n_psel++;
        if (bus.psel && bus.penable) n_acc++;
        bus.pready = busy && !mis && t == 2 + plan_waits;
        bus.prdata = plan_rdata;
        bus.pslverr = plan_err;
    endtask

    task automatic start_cmd(input logic [31:0] a, input logic w, input logic [31:0] d,
                             input int waits, input logic e, input logic [31:0] rd);
        int n;
        plan_waits = waits; plan_err = e; plan_rdata = rd;
        bus.cmd_addr = a; bus.cmd_write = w; bus.cmd_wdata = d; bus.cmd_valid = 1'b1;
        n_psel = 0; n_acc = 0; n = 0;
        while (!busy && n < 20) begin tick(); n++; end
        bus.cmd_valid = 1'b0;
        chk("accept", {63'd0, busy}, 64'd1);
    endtask

    task automatic do_cmd(input logic [31:0] a, input logic w, input logic [31:0] d,
                          input int waits, input logic e, input logic [31:0] rd, input int hold);
        start_cmd(a, w, d, waits, e, rd);
        lat = 0;
        while (!bus.rsp_valid && lat < 60) begin tick(); lat++; end
        chk("rsp_arrives", bus.rsp_valid, 1'b1);
        repeat (hold) tick();
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        bus.cmd_valid = 0; bus.cmd_addr = '0; bus.cmd_write = 0; bus.cmd_wdata = '0;
        bus.rsp_ready = 0; bus.prdata = '0; bus.pready = 0; bus.pslverr = 0;
        repeat (3) tick();
        chk("reset_cmd_ready", bus.cmd_ready, 1'b0);
        chk("reset_psel", bus.psel, 1'b0);
        rst_n = 1'b1;
        tick();

        do_cmd(32'h10, 1'b1, 32'hDEADBEEF, 0, 1'b0, 32'hCAFE0000, 0);
        chk("wr_lat", lat, 2);
        chk("wr_psel_cycles", n_psel, 2);
        chk("wr_access_cycles", n_acc, 1);
        chk("wr_rdata", bus.rsp_rdata, 32'h0);
        chk("wr_paddr", bus.paddr, 32'h10);
        chk("wr_pwdata", bus.pwdata, 32'hDEADBEEF);

        do_cmd(32'h24, 1'b0, 32'h0, 3, 1'b0, 32'h12345678, 0);
        chk("rd_lat", lat, 5);
        chk("rd_psel_cycles", n_psel, 5);
        chk("rd_rdata", bus.rsp_rdata, 32'h12345678);
        chk("rd_err", bus.rsp_err, 1'b0);

        do_cmd(32'h28, 1'b0, 32'h0, 0, 1'b1, 32'hFFFFFFFF, 1);
        chk("slverr_err", bus.rsp_err, 1'b1);
        chk("slverr_to", bus.rsp_timeout, 1'b0);
        chk("slverr_rdata", bus.rsp_rdata, 32'h0);

        do_cmd(32'h30, 1'b0, 32'h0, 100, 1'b0, 32'h55AA55AA, 0);
        chk("to_access_cycles", n_acc, 5);
        chk("to_psel", bus.psel, 1'b0);
        chk("to_err", bus.rsp_err, 1'b1);
        chk("to_flag", bus.rsp_timeout, 1'b1);

        do_cmd(32'h34, 1'b1, 32'h01020304, 1, 1'b0, 32'h0, 0);
        chk("after_to_err", bus.rsp_err, 1'b0);
        chk("after_to_flag", bus.rsp_timeout, 1'b0);
        chk("after_to_paddr", bus.paddr, 32'h34);

        do_cmd(32'h13, 1'b1, 32'h77777777, 0, 1'b0, 32'h0, 3);
        chk("mis_lat", lat, 0);
        chk("mis_psel_cycles", n_psel, 0);
        chk("mis_err", bus.rsp_err, 1'b1);
        chk("mis_paddr_kept", bus.paddr, 32'h34);

        start_cmd(32'h40, 1'b0, 32'h0, 10, 1'b0, 32'h0BADF00D);
        n = 0;
        while (n_acc < 2 && n < 10) begin tick(); n++; end
        chk("reached_access", n_acc, 2);
        rst_n = 1'b0;
        tick();
        chk("rst_psel", bus.psel, 1'b0);
        chk("rst_penable", bus.penable, 1'b0);
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        rst_n = 1'b1;
        repeat (3) tick();
        chk("post_rst_rsp_valid", bus.rsp_valid, 1'b0);

        do_cmd(32'h0, 1'b0, 32'h0, 0, 1'b0, 32'hA5A50001, 0);
        chk("post_rst_rdata", bus.rsp_rdata, 32'hA5A50001);
        chk("post_rst_err", bus.rsp_err, 1'b0);
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
